// File: rtl/psddivide_arbiter.sv
// Round-robin front end that shares one sequential divider datapath among NREQ requesters.
// Captures the winner's operands, sequences start/stop, and returns the result with a one-hot done.
module psddivide_arbiter #(
    parameter int NBITS = 32,
    parameter int NREQ  = 4,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*NBITS-1:0]   dividend_in,
    input  logic [NREQ*NBITS-1:0]   divisor_in,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic [NBITS-1:0]        quotient,
    output logic [NBITS-1:0]        rest,
    output logic                    dz,
    output logic                    busy,
    output logic [IDXW-1:0]         owner,
    output logic                    div_start,
    output logic                    div_stop,
    output logic [NBITS-1:0]        div_dividend,
    output logic [NBITS-1:0]        div_divisor,
    input  logic [NBITS-1:0]        div_quotient,
    input  logic [NBITS-1:0]        div_rest
);

    localparam int CNTW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NBITS - 1);
    localparam logic [IDXW:0]   NREQ_W   = (IDXW + 1)'(NREQ);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WORK  = 3'd2,
        STOP  = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   ptr_reg, ptr_next;
    logic [IDXW-1:0]   owner_reg, owner_next;
    logic [CNTW-1:0]   cnt_reg, cnt_next;
    logic [NBITS-1:0]  dividend_reg, dividend_next;
    logic [NBITS-1:0]  divisor_reg, divisor_next;
    logic [NBITS-1:0]  quotient_reg, quotient_next;
    logic [NBITS-1:0]  rest_reg, rest_next;
    logic              dz_reg, dz_next;

    logic [NBITS-1:0]  dividend_arr [NREQ];
    logic [NBITS-1:0]  divisor_arr  [NREQ];
    logic [IDXW-1:0]   winner;
    logic [IDXW-1:0]   owner_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign dividend_arr[gi] = dividend_in[gi*NBITS +: NBITS];
            assign divisor_arr[gi]  = divisor_in[gi*NBITS +: NBITS];
            assign grant[gi] = (state_reg == START) && (owner_reg == IDXW'(gi));
            assign done[gi]  = (state_reg == DONE)  && (owner_reg == IDXW'(gi));
        end
    endgenerate

    // Scan from the highest offset down so the requester closest to ptr overwrites the rest.
    always_comb begin
        logic [IDXW:0] cand;
        cand   = '0;
        winner = ptr_reg;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_reg} + (IDXW + 1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (req[cand[IDXW-1:0]]) begin
                winner = cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        logic [IDXW:0] inc;
        inc = {1'b0, owner_reg} + (IDXW + 1)'(1);
        if (inc >= NREQ_W) begin
            inc = '0;
        end
        owner_inc = inc[IDXW-1:0];
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        cnt_next      = cnt_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        quotient_next = quotient_reg;
        rest_next     = rest_reg;
        dz_next       = dz_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next    = START;
                    owner_next    = winner;
                    dividend_next = dividend_arr[winner];
                    divisor_next  = divisor_arr[winner];
                end
            end
            START: begin
                ptr_next = owner_inc;
                if (divisor_reg == '0) begin
                    // Skip the datapath entirely; the result is defined here.
                    state_next    = DONE;
                    quotient_next = '1;
                    rest_next     = dividend_reg;
                    dz_next       = 1'b1;
                end else begin
                    state_next = WORK;
                    cnt_next   = '0;
                end
            end
            WORK: begin
                cnt_next = cnt_reg + CNTW'(1);
                if (cnt_reg == CNT_LAST) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                state_next = FLUSH;
            end
            FLUSH: begin
                state_next    = DONE;
                quotient_next = div_quotient;
                rest_next     = div_rest;
                dz_next       = 1'b0;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            quotient_reg <= '0;
            rest_reg     <= '0;
            dz_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            cnt_reg      <= cnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            quotient_reg <= quotient_next;
            rest_reg     <= rest_next;
            dz_reg       <= dz_next;
        end
    end

    assign busy         = (state_reg != IDLE);
    assign owner        = owner_reg;
    assign div_start    = (state_reg == START) && (divisor_reg != '0);
    assign div_stop     = (state_reg == STOP);
    assign div_dividend = dividend_reg;
    assign div_divisor  = divisor_reg;
    assign quotient     = quotient_reg;
    assign rest         = rest_reg;
    assign dz           = dz_reg;

endmodule

// File: tb/tb_psddivide_arbiter.sv
// Directed bench for psddivide_arbiter (NBITS=8, NREQ=4) with a behavioural divider datapath.
module tb_psddivide_arbiter;

    localparam int NBITS = 8;
    localparam int NREQ  = 4;
    localparam int IDXW  = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*NBITS-1:0] dividend_in = '0;
    logic [NREQ*NBITS-1:0] divisor_in = '0;
    logic [NREQ-1:0]       grant, done;
    logic [NBITS-1:0]      quotient, rest;
    logic                  dz, busy;
    logic [IDXW-1:0]       owner;
    logic                  div_start, div_stop;
    logic [NBITS-1:0]      div_dividend, div_divisor;
    logic [NBITS-1:0]      div_quotient, div_rest;

    int n_cmp = 0;
    int n_err = 0;

    psddivide_arbiter #(.NBITS(NBITS), .NREQ(NREQ)) dut (
        .clock(clock), .reset(reset), .req(req),
        .dividend_in(dividend_in), .divisor_in(divisor_in),
        .grant(grant), .done(done), .quotient(quotient), .rest(rest),
        .dz(dz), .busy(busy), .owner(owner),
        .div_start(div_start), .div_stop(div_stop),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_rest(div_rest)
    );

    always #5 clock = ~clock;

    // Datapath stand-in: latches operands on start, loads its output registers on stop.
    logic [NBITS-1:0] op_a, op_b;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a <= '0; op_b <= '0; div_quotient <= '0; div_rest <= '0;
        end else begin
            if (div_start) begin
                op_a <= div_dividend;
                op_b <= div_divisor;
            end
            if (div_stop) begin
                div_quotient <= (op_b == 0) ? 8'hFF : op_a / op_b;
                div_rest     <= (op_b == 0) ? op_a  : op_a % op_b;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        dividend_in[i*NBITS +: NBITS] = a;
        divisor_in[i*NBITS +: NBITS]  = b;
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        if ($onehot(v)) begin
            for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        req   = '0;
        tick;
        n_cmp++;
        if ({grant, done, quotient, rest, dz, busy, owner, div_start, div_stop, div_dividend, div_divisor} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0",
                {grant, done, quotient, rest, dz, busy, owner, div_start, div_stop, div_dividend, div_divisor});
        end
        reset = 1'b0;
        tick;
        n_cmp++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_no_req: busy=%b grant=%b required busy=0 grant=0000", busy, grant);
        end
        $display("reset released, idle");
    endtask

    // Scenario 1: single job 100/7 on requester 0.
    task automatic test_single;
        logic [3:0] exp_done;
        req = 4'b0001;
        set_ops(0, 8'd100, 8'd7);
        tick;
        n_cmp++;
        if (grant !== 4'b0001 || div_start !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: grant=%b start=%b busy=%b required 0001/1/1", grant, div_start, busy);
        end
        req = '0;
        for (int k = 2; k <= 12; k++) begin
            tick;
            exp_done = (k == 12) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (busy !== 1'b1 || grant !== 4'b0000 || done !== exp_done) begin
                n_err++;
                $display("FAIL single_cycle%0d: busy=%b grant=%b done=%b required 1/0000/%b", k, busy, grant, done, exp_done);
            end
        end
        n_cmp++;
        if (quotient !== 8'd14 || rest !== 8'd2 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL single_result: q=%0d r=%0d dz=%b required 14/2/0", quotient, rest, dz);
        end
        $display("job req0 100/7 -> q=%0d r=%0d dz=%b", quotient, rest, dz);
        tick;
        n_cmp++;
        if (busy !== 1'b0 || done !== 4'b0000) begin
            n_err++;
            $display("FAIL single_idle: busy=%b done=%b required 0/0000", busy, done);
        end
    endtask

    // Scenario 2: all four requesters held from reset.
    task automatic test_back_to_back;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_q [4] = '{8'd6, 8'd7, 8'd7, 8'd7};
        logic [7:0] exp_r [4] = '{8'd2, 8'd0, 8'd1, 8'd2};
        int ng, nd, last_cyc, last_idx, gi, di;
        ng = 0; nd = 0; last_cyc = 0; last_idx = -1;
        reset = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(20 + i), 8'd3);
        tick;
        reset = 1'b0;
        for (int cyc = 1; cyc <= 66; cyc++) begin
            tick;
            if (cyc == 60) req = '0;
            n_cmp++;
            if ((done != 0 && (grant != 0 || div_start || div_stop)) || (div_stop && (grant != 0 || div_start))) begin
                n_err++;
                $display("FAIL b2b_exclusive cyc%0d: grant=%b done=%b start=%b stop=%b required no overlap",
                    cyc, grant, done, div_start, div_stop);
            end
            if (grant != 0) begin
                gi = idx_of(grant);
                n_cmp++;
                if (ng >= 5 || gi != exp_order[ng] || (ng > 0 && cyc - last_cyc != 13)) begin
                    n_err++;
                    $display("FAIL b2b_grant%0d: idx=%0d cyc=%0d prev=%0d required idx=%0d spacing 13",
                        ng, gi, cyc, last_cyc, (ng < 5) ? exp_order[ng] : -1);
                end
                $display("grant idx=%0d at cycle %0d", gi, cyc);
                last_cyc = cyc; last_idx = gi; ng++;
            end
            if (done != 0) begin
                di = idx_of(done);
                n_cmp++;
                if (di != last_idx || di < 0 || quotient !== exp_q[di] || rest !== exp_r[di]) begin
                    n_err++;
                    $display("FAIL b2b_done%0d: idx=%0d q=%0d r=%0d required idx=%0d q=%0d r=%0d",
                        nd, di, quotient, rest, last_idx, (last_idx >= 0) ? exp_q[last_idx] : 0,
                        (last_idx >= 0) ? exp_r[last_idx] : 0);
                end
                $display("done idx=%0d q=%0d r=%0d", di, quotient, rest);
                nd++;
            end
        end
        n_cmp++;
        if (ng != 5 || nd != 5 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_count: grants=%0d dones=%0d busy=%b required 5/5/0", ng, nd, busy);
        end
    endtask

    // Scenario 3: divide by zero on requester 2.
    task automatic test_divzero;
        req = 4'b0100;
        set_ops(2, 8'd55, 8'd0);
        tick;
        n_cmp++;
        if (grant !== 4'b0100 || div_start !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL dz_grant: grant=%b start=%b busy=%b required 0100/0/1", grant, div_start, busy);
        end
        req = '0;
        tick;
        n_cmp++;
        if (done !== 4'b0100 || quotient !== 8'hFF || rest !== 8'd55 || dz !== 1'b1 || div_start !== 1'b0) begin
            n_err++;
            $display("FAIL dz_done: done=%b q=%h r=%0d dz=%b start=%b required 0100/ff/55/1/0",
                done, quotient, rest, dz, div_start);
        end
        $display("job req2 55/0 -> q=%h r=%0d dz=%b", quotient, rest, dz);
        tick;
        n_cmp++;
        if (busy !== 1'b0 || done !== 4'b0000) begin
            n_err++;
            $display("FAIL dz_idle: busy=%b done=%b required 0/0000", busy, done);
        end
    endtask

    // Scenario 4: reset pulse in cycle 5 of a 200/3 job, then the job reruns.
    task automatic test_reset_mid;
        logic [3:0] exp_done;
        req = 4'b0010;
        set_ops(1, 8'd200, 8'd3);
        tick;
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_err++;
            $display("FAIL rmid_grant: grant=%b required 0010", grant);
        end
        repeat (4) tick;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({grant, done, quotient, rest, dz, busy, owner, div_start, div_stop, div_dividend, div_divisor} !== '0) begin
            n_err++;
            $display("FAIL rmid_async: got %h required 0",
                {grant, done, quotient, rest, dz, busy, owner, div_start, div_stop, div_dividend, div_divisor});
        end
        tick;
        n_cmp++;
        if (done !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_held: done=%b busy=%b required 0000/0", done, busy);
        end
        reset = 1'b0;
        tick;
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_err++;
            $display("FAIL rmid_regrant: grant=%b required 0010", grant);
        end
        req = '0;
        for (int k = 2; k <= 12; k++) begin
            tick;
            exp_done = (k == 12) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL rmid_cycle%0d: done=%b required %b", k, done, exp_done);
            end
        end
        n_cmp++;
        if (quotient !== 8'd66 || rest !== 8'd2 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_result: q=%0d r=%0d dz=%b required 66/2/0", quotient, rest, dz);
        end
        $display("job req1 200/3 after reset -> q=%0d r=%0d", quotient, rest);
        tick;
    endtask

    // Scenario 5: requesters 1 and 3 rise together just after reset.
    task automatic test_pair;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        set_ops(0, 8'd7, 8'd7);
        set_ops(1, 8'd9, 8'd2);
        set_ops(3, 8'd50, 8'd5);
        req = 4'b1010;
        tick;
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_err++;
            $display("FAIL pair_first: grant=%b required 0010", grant);
        end
        req = 4'b1000;
        for (int t = 0; t < 20 && done === 4'b0000; t++) tick;
        n_cmp++;
        if (done !== 4'b0010 || quotient !== 8'd4 || rest !== 8'd1) begin
            n_err++;
            $display("FAIL pair_done1: done=%b q=%0d r=%0d required 0010/4/1", done, quotient, rest);
        end
        $display("job req1 9/2 -> q=%0d r=%0d", quotient, rest);
        req = 4'b1011;
        tick;
        tick;
        n_cmp++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            n_err++;
            $display("FAIL pair_second: grant=%b owner=%0d required 1000/3", grant, owner);
        end
        req = 4'b0011;
        for (int t = 0; t < 20 && done === 4'b0000; t++) tick;
        n_cmp++;
        if (done !== 4'b1000 || quotient !== 8'd10 || rest !== 8'd0) begin
            n_err++;
            $display("FAIL pair_done2: done=%b q=%0d r=%0d required 1000/10/0", done, quotient, rest);
        end
        $display("job req3 50/5 -> q=%0d r=%0d", quotient, rest);
        tick;
        tick;
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_err++;
            $display("FAIL pair_wrap: grant=%b required 0001", grant);
        end
        req = '0;
        for (int t = 0; t < 20 && done === 4'b0000; t++) tick;
        n_cmp++;
        if (done !== 4'b0001 || quotient !== 8'd1 || rest !== 8'd0) begin
            n_err++;
            $display("FAIL pair_done3: done=%b q=%0d r=%0d required 0001/1/0", done, quotient, rest);
        end
        $display("job req0 7/7 -> q=%0d r=%0d", quotient, rest);
        tick;
    endtask

    // Scenario 6: 3/9 on requester 3, owner tracked across the whole job.
    task automatic test_owner;
        logic [3:0] exp_done;
        req = 4'b1000;
        set_ops(3, 8'd3, 8'd9);
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 2) req = '0;
            exp_done = (k == 12) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if (owner !== 2'd3 || busy !== 1'b1 || done !== exp_done) begin
                n_err++;
                $display("FAIL owner_cycle%0d: owner=%0d busy=%b done=%b required 3/1/%b", k, owner, busy, done, exp_done);
            end
        end
        n_cmp++;
        if (quotient !== 8'd0 || rest !== 8'd3 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL owner_result: q=%0d r=%0d dz=%b required 0/3/0", quotient, rest, dz);
        end
        $display("job req3 3/9 -> q=%0d r=%0d", quotient, rest);
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_divzero;
        test_reset_mid;
        test_pair;
        test_owner;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
